riscv_run_monitor: RTL and testbench
====================================

// Module: riscv_run_monitor
// PURPOSE
//  Run-control and trace monitor for the RISC-V single-cycle core. Sequences the core reset,
//  then records the PC and instruction of every executed cycle in a circular trace buffer.
//  Ends the run on stop address, PC stall or cycle timeout. Status and trace are readable
//  by the bench or debug logic, so runs no longer need fixed wall-clock delays.
// PARAMETERS
//  XLEN          32    PC width
//  DEPTH         16    trace entries; power of 2, >=2
//  RST_CYCLES    1     cycles core_rst_o is held high after start
//  STALL_LIMIT   8     consecutive unchanged-PC cycles that flag a stall; >=1
//  MAX_CYCLES    1024  RUN-cycle budget before timeout
// PORTS
//  clk         in   1              clock, rising edge
//  reset       in   1              asynchronous, active-high
//  start       in   1              pulse; accepted in IDLE or DONE, ignored otherwise
//  stop_pc_i   in   XLEN           PC value that ends the run
//  pc_i        in   XLEN           core PC
//  instr_i     in   32             core instruction at pc_i
//  core_rst_o  out  1              reset to core
//  run_o       out  1              high in RUN
//  done_o      out  1              high in DONE
//  timeout_o   out  1              run ended by MAX_CYCLES
//  stall_o     out  1              run ended by STALL_LIMIT
//  cycle_cnt_o out  clog2(MAX_CYCLES+1)  RUN cycles sampled
//  fill_o      out  clog2(DEPTH+1) valid trace entries
//  rd_addr_i   in   clog2(DEPTH)   trace index, 0 = oldest valid entry
//  rd_pc_o     out  XLEN           registered trace PC, 1-cycle latency
//  rd_instr_o  out  32             registered trace instruction, 1-cycle latency
//  sig_o       out  32             run signature (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; core_rst_o=1; all other outputs, counters and pointers 0. Applies mid-run.
//  FSM: IDLE -start-> RST; RST holds core_rst_o=1 for RST_CYCLES, then -> RUN (core_rst_o=0).
//   RUN: each cycle write {pc_i,instr_i} at wr_ptr; wr_ptr wraps DEPTH-1->0.
//   RUN: fill saturates at DEPTH; cycle_cnt +1.
//   RUN -> DONE on the cycle after end condition.
//   End-condition priority, same cycle: pc_i==stop_pc_i (clean) > stall > timeout.
//   DONE -start-> RST; restart clears cycle_cnt, fill, wr_ptr, flags and sig.
//   In DONE, core_rst_o=1 to freeze core.
//  Stall: counter increments when pc_i equals previous RUN sample, else clears.
//   Stall flags when counter reaches STALL_LIMIT.
//   First RUN cycle has no previous sample.
//  Timeout: when cycle_cnt becomes MAX_CYCLES, including the current sample.
//  Flags set on entry to DONE; held until restart or reset. At most one flag set; clean stop sets none.
//  Read: entry addressed = (wr_ptr - fill + rd_addr_i) mod DEPTH.
//   If rd_addr_i>=fill, outputs 0.
//   Reads are legal in any state.
// CONFIGURATION
//  RUN_MONITOR_SIG_EN defined: sig_o updates each RUN cycle:
//   sig = {sig[30:0],sig[31]} ^ pc_i[31:0] ^ instr_i.
//  Not defined: sig_o tied 0; no signature logic.
// STRUCTURE
//  Package riscv_run_pkg holds:
//   state typedef (IDLE,RST,RUN,DONE) and trace entry struct {pc,instr}.
//   Width constants PTR_W=clog2(DEPTH) and CNT_W=clog2(MAX_CYCLES+1).
//  Sub-module run_trace_buf: circular buffer, write port, registered read port, fill count.
//  FSM, counters and signature live in top.
// TESTING
//  1 start, stop_pc=0xC, pc 0,4,8,C: done_o after 4 RUN cycles; cycle_cnt=4, fill=4.
//    Same run: rd_addr 3 -> pc 0xC; no flags.
//  2 DEPTH=16, pc 0..0x4C step 4, stop 0x4C: fill=16, rd_addr0->0x10, rd_addr15->0x4C.
//  3 pc stuck at 0x8 from cycle 3: stall_o=1, done_o=1 after 8 equal compares.
//    Same run: core_rst_o=1.
//  4 no stop, pc increments: timeout_o=1, cycle_cnt=1024.
//  5 stop_pc hit on cycle 1024: done_o=1, timeout_o=0.
//  6 reset asserted mid-RUN: immediately core_rst_o=1, run_o=0, fill=0.
//    Then start: RST for RST_CYCLES, then RUN, and trace restarts at 0.
//  With RUN_MONITOR_SIG_EN, bench reference model of sig_o must match after test 1.

Source files
------------

// File: rtl/riscv_run_pkg.sv
// Shared types and width constants for the RISC-V run monitor and its trace buffer.
package riscv_run_pkg;

    localparam int unsigned XLEN_W         = 32;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_MAX_CYCLES = 1024;
    localparam int unsigned PTR_W          = $clog2(DEF_DEPTH);
    localparam int unsigned CNT_W          = $clog2(DEF_MAX_CYCLES + 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RST  = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [31:0]       instr;
    } trace_entry_t;

endpackage

// File: rtl/run_trace_buf.sv
// Circular trace buffer: one write per cycle, saturating fill count and a registered
// read port addressed relative to the oldest valid entry.
module run_trace_buf
    import riscv_run_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  trace_entry_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output trace_entry_t               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    trace_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_idx;

    // DEPTH is a power of two, so the low fill bits give the oldest entry modulo DEPTH.
    assign rd_idx = wr_ptr - fill[AW-1:0] + rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            fill    <= '0;
            rd_data <= '0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                fill   <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != FW'(DEPTH)) begin
                    fill <= fill + FW'(1);
                end
            end
            rd_data <= (FW'(rd_addr) < fill) ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/riscv_run_monitor.sv
// Run-control and trace monitor: sequences core reset, traces every RUN cycle and ends
// the run on stop PC, stall or timeout. Optional signature enabled by RUN_MONITOR_SIG_EN.
module riscv_run_monitor
    import riscv_run_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned RST_CYCLES  = 1,
    parameter int unsigned STALL_LIMIT = 8,
    parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [XLEN-1:0]                 stop_pc_i,
    input  logic [XLEN-1:0]                 pc_i,
    input  logic [31:0]                     instr_i,
    output logic                            core_rst_o,
    output logic                            run_o,
    output logic                            done_o,
    output logic                            timeout_o,
    output logic                            stall_o,
    output logic [$clog2(MAX_CYCLES+1)-1:0] cycle_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0]      fill_o,
    input  logic [$clog2(DEPTH)-1:0]        rd_addr_i,
    output logic [XLEN-1:0]                 rd_pc_o,
    output logic [31:0]                     rd_instr_o,
    output logic [31:0]                     sig_o
);

    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);

    state_t          state, state_nxt;
    logic            start_clr;
    logic [RW-1:0]   rst_cnt;
    logic [CW-1:0]   cycle_cnt, cnt_inc;
    logic [SW-1:0]   stall_cnt, stall_nxt;
    logic [XLEN-1:0] prev_pc;
    logic            have_prev;
    logic            hit_stop, hit_stall, hit_tmo, end_run;
    trace_entry_t    wr_entry, rd_entry;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and end-condition evaluation on the current RUN sample
    always_comb begin
        state_nxt = state;
        start_clr = 1'b0;
        cnt_inc   = cycle_cnt + CW'(1);
        stall_nxt = (have_prev && (pc_i == prev_pc)) ? stall_cnt + SW'(1) : '0;
        hit_stop  = (pc_i == stop_pc_i);
        hit_stall = (stall_nxt == SW'(STALL_LIMIT));
        hit_tmo   = (cnt_inc == CW'(MAX_CYCLES));
        end_run   = hit_stop || hit_stall || hit_tmo;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RST;
                    start_clr = 1'b1;
                end
            end
            ST_RST: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (end_run) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs, counters and termination flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rst_o <= 1'b1;
            run_o      <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            stall_o    <= 1'b0;
            rst_cnt    <= '0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            prev_pc    <= '0;
            have_prev  <= 1'b0;
        end else begin
            core_rst_o <= (state_nxt != ST_RUN);
            run_o      <= (state_nxt == ST_RUN);
            done_o     <= (state_nxt == ST_DONE);
            rst_cnt    <= ((state == ST_RST) && (state_nxt == ST_RST)) ? rst_cnt + RW'(1) : '0;
            if (start_clr) begin
                timeout_o <= 1'b0;
                stall_o   <= 1'b0;
                cycle_cnt <= '0;
                stall_cnt <= '0;
                have_prev <= 1'b0;
            end else if (state == ST_RUN) begin
                cycle_cnt <= cnt_inc;
                stall_cnt <= stall_nxt;
                prev_pc   <= pc_i;
                have_prev <= 1'b1;
                if (end_run) begin
                    stall_o   <= !hit_stop && hit_stall;
                    timeout_o <= !hit_stop && !hit_stall && hit_tmo;
                end
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt;
    assign wr_entry    = '{pc: pc_i, instr: instr_i};

    run_trace_buf #(
        .DEPTH (DEPTH)
    ) u_trace (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_clr),
        .wr_en   (state == ST_RUN),
        .wr_data (wr_entry),
        .rd_addr (rd_addr_i),
        .rd_data (rd_entry),
        .fill    (fill_o)
    );

    assign rd_pc_o    = rd_entry.pc;
    assign rd_instr_o = rd_entry.instr;

`ifdef RUN_MONITOR_SIG_EN
    logic [31:0] sig;

    // Rotate-and-fold signature over every traced sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig <= '0;
        end else if (start_clr) begin
            sig <= '0;
        end else if (state == ST_RUN) begin
            sig <= {sig[30:0], sig[31]} ^ pc_i[31:0] ^ instr_i;
        end
    end

    assign sig_o = sig;
`else
    assign sig_o = '0;
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Randomized self-checking bench for riscv_run_monitor; the reference model works on the
// list of presented samples. Signature is checked when RUN_MONITOR_SIG_EN is defined.
module tb_riscv_run_monitor;

    localparam int DEPTH       = 16;
    localparam int RST_CYCLES  = 1;
    localparam int STALL_LIMIT = 8;
    localparam int MAX_CYCLES  = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] stop_pc_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic        core_rst_o, run_o, done_o, timeout_o, stall_o;
    logic [10:0] cycle_cnt_o;
    logic [4:0]  fill_o;
    logic [3:0]  rd_addr_i = '0;
    logic [31:0] rd_pc_o, rd_instr_o, sig_o;

    int checks = 0;
    int errors = 0;

    riscv_run_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop_pc_i   (stop_pc_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .core_rst_o  (core_rst_o),
        .run_o       (run_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .stall_o     (stall_o),
        .cycle_cnt_o (cycle_cnt_o),
        .fill_o      (fill_o),
        .rd_addr_i   (rd_addr_i),
        .rd_pc_o     (rd_pc_o),
        .rd_instr_o  (rd_instr_o),
        .sig_o       (sig_o)
    );

    always #5 clk = ~clk;

    // Starts a run and plays a PC stream until the model says it ends, then checks
    // status and the whole trace window. mode: 0 incrementing, 1 stuck at 0x8 from
    // the third cycle, 2 random walk, 3 sticky random walk. Returns sample count.
    task automatic do_run(input int mode, input logic [31:0] stop, output int n_out);
        logic [31:0] qpc[$];
        logic [31:0] qins[$];
        logic [31:0] pc, ins, sig_m, exp_pc, exp_ins;
        int n, eq_run, f;
        bit ended, hs, hst, ht, exp_stall, exp_tmo;
        ended = 0; n = 0; sig_m = '0; pc = '0; exp_stall = 0; exp_tmo = 0;
        @(negedge clk);
        start = 1'b1; stop_pc_i = stop;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (core_rst_o !== 1'b1 || run_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_phase rst=%b run=%b done=%b want 1 0 0", core_rst_o, run_o, done_o);
        end
        checks++;
        if (cycle_cnt_o !== 11'd0 || fill_o !== 5'd0 || stall_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear cnt=%0d fill=%0d stall=%b tmo=%b want 0", cycle_cnt_o, fill_o, stall_o, timeout_o);
        end
        repeat (RST_CYCLES - 1) @(negedge clk);
        @(negedge clk);
        checks++;
        if (run_o !== 1'b1 || core_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL run_entry run=%b rst=%b want 1 0", run_o, core_rst_o);
        end
        while (!ended && n < MAX_CYCLES + 8) begin
            case (mode)
                0: pc = 32'(n * 4);
                1: pc = (n < 2) ? 32'(n * 4) : 32'h8;
                2: pc = (n > 0 && $urandom_range(3) == 0) ? pc : {24'd0, 6'($urandom_range(63)), 2'b00};
                default: pc = (n > 0 && $urandom_range(7) != 0) ? pc : {24'd0, 6'($urandom_range(63)), 2'b00};
            endcase
            ins = $urandom;
            pc_i = pc; instr_i = ins;
            qpc.push_back(pc); qins.push_back(ins);
            n++;
            sig_m = {sig_m[30:0], sig_m[31]} ^ pc ^ ins;
            @(posedge clk);
            @(negedge clk);
            eq_run = 0;
            for (int j = n - 1; j > 0 && qpc[j] == qpc[j-1]; j--) eq_run++;
            hs  = (pc == stop);
            hst = (eq_run == STALL_LIMIT);
            ht  = (n == MAX_CYCLES);
            ended = hs || hst || ht;
            exp_stall = !hs && hst;
            exp_tmo   = !hs && !hst && ht;
            checks++;
            if (run_o !== !ended || done_o !== ended) begin
                errors++;
                $display("FAIL run_state n=%0d run=%b done=%b want %b %b", n, run_o, done_o, !ended, ended);
            end
        end
        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL run_bound model never ended after %0d samples", n);
        end
        f = (n < DEPTH) ? n : DEPTH;
        checks++;
        if (cycle_cnt_o !== 11'(n) || fill_o !== 5'(f)) begin
            errors++;
            $display("FAIL counts cnt=%0d fill=%0d want %0d %0d", cycle_cnt_o, fill_o, n, f);
        end
        checks++;
        if (stall_o !== exp_stall || timeout_o !== exp_tmo || core_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL flags stall=%b tmo=%b rst=%b want %b %b 1", stall_o, timeout_o, core_rst_o, exp_stall, exp_tmo);
        end
`ifdef RUN_MONITOR_SIG_EN
        checks++;
        if (sig_o !== sig_m) begin
            errors++;
            $display("FAIL signature got %08h want %08h", sig_o, sig_m);
        end
`else
        checks++;
        if (sig_o !== 32'd0) begin
            errors++;
            $display("FAIL signature_off got %08h want 0 (model %08h)", sig_o, sig_m);
        end
`endif
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_i = 4'(a);
            @(posedge clk);
            @(negedge clk);
            exp_pc  = (a < f) ? qpc[n - f + a] : 32'd0;
            exp_ins = (a < f) ? qins[n - f + a] : 32'd0;
            checks++;
            if (rd_pc_o !== exp_pc || rd_instr_o !== exp_ins) begin
                errors++;
                $display("FAIL trace[%0d] pc=%08h ins=%08h want %08h %08h", a, rd_pc_o, rd_instr_o, exp_pc, exp_ins);
            end
        end
        n_out = n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (core_rst_o !== 1'b1 || run_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl rst=%b run=%b done=%b stall=%b tmo=%b want 1 0 0 0 0",
                     core_rst_o, run_o, done_o, stall_o, timeout_o);
        end
        checks++;
        if (cycle_cnt_o !== 11'd0 || fill_o !== 5'd0 || sig_o !== 32'd0 || rd_pc_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_data cnt=%0d fill=%0d sig=%08h rdpc=%08h want 0", cycle_cnt_o, fill_o, sig_o, rd_pc_o);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (core_rst_o !== 1'b1 || run_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold rst=%b run=%b want 1 0", core_rst_o, run_o);
        end
    endtask

    task automatic test_clean_stop();
        int n;
        do_run(0, 32'hC, n);
        checks++;
        if (n !== 4 || cycle_cnt_o !== 11'd4 || fill_o !== 5'd4) begin
            errors++;
            $display("FAIL clean_stop n=%0d cnt=%0d fill=%0d want 4 4 4", n, cycle_cnt_o, fill_o);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_run(0, 32'h4C, n);
        checks++;
        if (fill_o !== 5'd16 || cycle_cnt_o !== 11'd20) begin
            errors++;
            $display("FAIL wrap fill=%0d cnt=%0d want 16 20", fill_o, cycle_cnt_o);
        end
    endtask

    task automatic test_stall();
        int n;
        do_run(1, 32'hFFFF_FFF0, n);
        checks++;
        if (stall_o !== 1'b1 || cycle_cnt_o !== 11'd11 || core_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL stall stall=%b cnt=%0d rst=%b want 1 11 1", stall_o, cycle_cnt_o, core_rst_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_run(0, 32'hFFFF_0000, n);
        checks++;
        if (timeout_o !== 1'b1 || cycle_cnt_o !== 11'd1024) begin
            errors++;
            $display("FAIL timeout tmo=%b cnt=%0d want 1 1024", timeout_o, cycle_cnt_o);
        end
    endtask

    task automatic test_stop_at_limit();
        int n;
        do_run(0, 32'(4 * (MAX_CYCLES - 1)), n);
        checks++;
        if (done_o !== 1'b1 || timeout_o !== 1'b0 || cycle_cnt_o !== 11'd1024) begin
            errors++;
            $display("FAIL stop_at_limit done=%b tmo=%b cnt=%0d want 1 0 1024", done_o, timeout_o, cycle_cnt_o);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 6; r++) begin
            do_run(2 + (r % 2), {24'd0, 6'($urandom_range(63)), 2'b00}, n);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        @(negedge clk);
        start = 1'b1; stop_pc_i = 32'hFFFF_0000;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pc_i = 32'(k * 4); instr_i = $urandom;
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (core_rst_o !== 1'b1 || run_o !== 1'b0 || fill_o !== 5'd0 || cycle_cnt_o !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset rst=%b run=%b fill=%0d cnt=%0d want 1 0 0 0", core_rst_o, run_o, fill_o, cycle_cnt_o);
        end
        @(negedge clk);
        reset = 1'b0;
        do_run(0, 32'h10, n);
        checks++;
        if (fill_o !== 5'd5) begin
            errors++;
            $display("FAIL after_reset fill=%0d want 5", fill_o);
        end
    endtask

    initial begin
        test_reset();
        test_clean_stop();
        test_wrap();
        test_stall();
        test_timeout();
        test_stop_at_limit();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
